// File: rtl/json_pkg.sv
// Shared types and byte constants for the JSON object encoder.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package json_pkg;

  typedef enum logic [1:0] {
    ENC_INT  = 2'd0,
    ENC_STR  = 2'd1,
    ENC_BOOL = 2'd2,
    ENC_NULL = 2'd3
  } json_enc_type_e;

  typedef enum logic [1:0] {
    ENC_OK       = 2'd0,
    ENC_BAD_KEY  = 2'd1,
    ENC_BAD_STR  = 2'd2,
    ENC_BAD_CHAR = 2'd3
  } json_enc_status_e;

  localparam logic [7:0] JSON_CH_LBRACE = 8'h7B;
  localparam logic [7:0] JSON_CH_RBRACE = 8'h7D;
  localparam logic [7:0] JSON_CH_QUOTE  = 8'h22;
  localparam logic [7:0] JSON_CH_COLON  = 8'h3A;
  localparam logic [7:0] JSON_CH_COMMA  = 8'h2C;
  localparam logic [7:0] JSON_CH_MINUS  = 8'h2D;
  localparam logic [7:0] JSON_CH_BSLASH = 8'h5C;
  localparam logic [7:0] JSON_CH_ZERO   = 8'h30;

  // Bytes that cannot appear unescaped inside a JSON string.
  function automatic logic is_special(input logic [7:0] c);
    return (c == JSON_CH_QUOTE) || (c == JSON_CH_BSLASH) || (c < 8'h20);
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  // Number of output bytes a source byte expands to when escaping.
  function automatic logic [2:0] esc_len(input logic [7:0] c);
    logic [2:0] r;
    r = 3'd1;
    if (c < 8'h20) r = 3'd6;
    else if ((c == JSON_CH_QUOTE) || (c == JSON_CH_BSLASH)) r = 3'd2;
    return r;
  endfunction

  // Byte 'pos' of the escaped form of c: \" \\ or \u00XX.
  function automatic logic [7:0] esc_char(input logic [7:0] c, input logic [2:0] pos);
    logic [7:0] r;
    r = c;
    if (c < 8'h20) begin
      case (pos)
        3'd0:    r = JSON_CH_BSLASH;
        3'd1:    r = 8'h75;
        3'd2:    r = JSON_CH_ZERO;
        3'd3:    r = JSON_CH_ZERO;
        3'd4:    r = hex_char(c[7:4]);
        default: r = hex_char(c[3:0]);
      endcase
    end else if ((c == JSON_CH_QUOTE) || (c == JSON_CH_BSLASH)) begin
      r = (pos == 3'd0) ? JSON_CH_BSLASH : c;
    end
    return r;
  endfunction

  // Literal text for true/false/null, byte 0 first.
  function automatic logic [7:0] lit_char(input logic is_null, input logic bval, input logic [2:0] pos);
    logic [4:0][7:0] s;
    if (is_null)   s = 40'h00_6C_6C_75_6E;
    else if (bval) s = 40'h00_65_75_72_74;
    else           s = 40'h65_73_6C_61_66;
    return (pos < 3'd5) ? s[pos] : 8'h00;
  endfunction

  function automatic logic [2:0] lit_len(input logic is_null, input logic bval);
    return (is_null || bval) ? 3'd4 : 3'd5;
  endfunction

endpackage

// File: rtl/json_int2dec.sv
// Signed 32-bit to decimal digit buffer, least significant digit first.
// Latency: magnitude latched on start; one digit per step cycle, done on the last digit.
// Backpressure: none; the caller paces conversion with step.
module json_int2dec
  import json_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [31:0]     value,
  input  logic            step,
  output logic            done,
  output logic [9:0][3:0] digits,
  output logic [3:0]      ndigits,
  output logic            neg
);

  logic [31:0] mag;

  // The step that consumes the final (most significant) digit ends the conversion;
  // a zero magnitude still produces one digit.
  assign done = step && (mag < 32'd10);

  // Latch |value| on start, then peel off one decimal digit per step.
  always_ff @(posedge clk) begin
    if (rst) begin
      mag     <= '0;
      neg     <= 1'b0;
      ndigits <= '0;
      digits  <= '0;
    end else if (start) begin
      // Two's-complement negate as unsigned: -2^31 maps to 2^31.
      mag     <= value[31] ? (32'd0 - value) : value;
      neg     <= value[31];
      ndigits <= '0;
      digits  <= '0;
    end else if (step) begin
      digits[ndigits] <= 4'(mag % 32'd10);
      mag             <= mag / 32'd10;
      ndigits         <= ndigits + 4'd1;
    end
  end

endmodule

// File: rtl/json_obj_encoder.sv
// Serializes key/value field records into JSON object text, one byte per beat.
// Latency: first byte the cycle after record accept; integers add one idle cycle per digit.
// Backpressure: valid/ready on both sides; one record in flight, output held while out_ready low.
// Build option JSON_ENC_ESCAPE_EN: escape '"', '\' and control bytes instead of rejecting them.
module json_obj_encoder
  import json_pkg::*;
#(
  parameter int MAX_KEY = 8,
  parameter int MAX_STR = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         fld_valid,
  output logic                         fld_ready,
  input  logic [8*MAX_KEY-1:0]         fld_key,
  input  logic [$clog2(MAX_KEY+1)-1:0] fld_key_len,
  input  logic [1:0]                   fld_type,
  input  logic [31:0]                  fld_int,
  input  logic [8*MAX_STR-1:0]         fld_str,
  input  logic [$clog2(MAX_STR+1)-1:0] fld_str_len,
  input  logic                         fld_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [7:0]                   out_data,
  output logic                         out_last,
  output logic                         err_valid,
  output logic [1:0]                   err_code
);

  localparam int KLW = $clog2(MAX_KEY + 1);
  localparam int SLW = $clog2(MAX_STR + 1);
  localparam int KIW = $clog2(MAX_KEY);
  localparam int SIW = $clog2(MAX_STR);

  typedef enum logic [3:0] {
    S_IDLE, S_OPEN, S_COMMA, S_KQ1, S_KEY, S_KQ2, S_COLON,
    S_SQ1, S_STR, S_SQ2, S_LIT, S_CONV, S_NUM, S_CLOSE
  } state_e;

  state_e                   state, state_n;
  logic [MAX_KEY-1:0][7:0]  rec_key;
  logic [KLW-1:0]           rec_key_len;
  json_enc_type_e           rec_type;
  logic                     rec_bool;
  logic [MAX_STR-1:0][7:0]  rec_str;
  logic [SLW-1:0]           rec_str_len;
  logic                     rec_last;
  logic                     rec_bad;
  logic                     in_obj, in_obj_n;
  logic                     first_fld, first_n;
  logic [7:0]               idx, idx_n;
  logic [2:0]               esc_pos, esc_n;

  json_enc_type_e           in_type;
  json_enc_status_e         chk_code;
  logic                     accept;

  logic [7:0]               cur_byte, cur_out, cur_total;
  logic [2:0]               cur_len;

  logic                     step, conv_done, neg;
  logic [9:0][3:0]          digits;
  logic [3:0]               ndigits, dpos;
  logic [7:0]               num_total;

  assign in_type   = json_enc_type_e'(fld_type);
  assign fld_ready = (state == S_IDLE) && !rst;
  assign accept    = fld_valid && fld_ready;

  json_int2dec u_int2dec (
    .clk     (clk),
    .rst     (rst),
    .start   (accept),
    .value   (fld_int),
    .step    (step),
    .done    (conv_done),
    .digits  (digits),
    .ndigits (ndigits),
    .neg     (neg)
  );

  // Validate an offered record; the verdict is only used on accept.
  always_comb begin
    chk_code = ENC_OK;
    if ((fld_key_len == '0) || (fld_key_len > KLW'(MAX_KEY))) begin
      chk_code = ENC_BAD_KEY;
    end else if ((in_type == ENC_STR) && (fld_str_len > SLW'(MAX_STR))) begin
      chk_code = ENC_BAD_STR;
    end
`ifndef JSON_ENC_ESCAPE_EN
    else begin
      for (int i = 0; i < MAX_KEY; i++) begin
        if ((KLW'(i) < fld_key_len) && is_special(fld_key[8*i +: 8])) chk_code = ENC_BAD_CHAR;
      end
      for (int i = 0; i < MAX_STR; i++) begin
        if ((in_type == ENC_STR) && (SLW'(i) < fld_str_len) && is_special(fld_str[8*i +: 8]))
          chk_code = ENC_BAD_CHAR;
      end
    end
`endif
  end

  // Current key/string byte and its (possibly escaped) expansion.
  always_comb begin
    cur_byte  = (state == S_KEY) ? rec_key[idx[KIW-1:0]] : rec_str[idx[SIW-1:0]];
    cur_total = (state == S_KEY) ? 8'(rec_key_len) : 8'(rec_str_len);
`ifdef JSON_ENC_ESCAPE_EN
    cur_len   = esc_len(cur_byte);
    cur_out   = esc_char(cur_byte, esc_pos);
`else
    cur_len   = 3'd1;
    cur_out   = cur_byte;
`endif
  end

  // Number emission: optional sign, then digits most significant first.
  always_comb begin
    num_total = {4'h0, ndigits} + {7'h0, neg};
    dpos      = ndigits - 4'd1 - (idx[3:0] - {3'b000, neg});
  end

  // Next-state, output byte and object bookkeeping.
  always_comb begin
    state_n   = state;
    idx_n     = idx;
    esc_n     = esc_pos;
    in_obj_n  = in_obj;
    first_n   = first_fld;
    out_valid = 1'b0;
    out_data  = 8'h00;
    out_last  = 1'b0;
    step      = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          idx_n = '0;
          esc_n = '0;
          if (chk_code != ENC_OK) state_n = fld_last ? (in_obj ? S_CLOSE : S_OPEN) : S_IDLE;
          else if (!in_obj)       state_n = S_OPEN;
          else                    state_n = first_fld ? S_KQ1 : S_COMMA;
        end
      end
      S_OPEN: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_LBRACE;
        if (out_ready) begin
          in_obj_n = 1'b1;
          state_n  = rec_bad ? S_CLOSE : (first_fld ? S_KQ1 : S_COMMA);
        end
      end
      S_COMMA: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_COMMA;
        if (out_ready) state_n = S_KQ1;
      end
      S_KQ1: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_QUOTE;
        if (out_ready) state_n = S_KEY;
      end
      S_KEY, S_STR: begin
        out_valid = 1'b1;
        out_data  = cur_out;
        if (out_ready) begin
          if (esc_pos == (cur_len - 3'd1)) begin
            esc_n = '0;
            if ((idx + 8'd1) == cur_total) begin
              idx_n   = '0;
              state_n = (state == S_KEY) ? S_KQ2 : S_SQ2;
            end else begin
              idx_n = idx + 8'd1;
            end
          end else begin
            esc_n = esc_pos + 3'd1;
          end
        end
      end
      S_KQ2: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_QUOTE;
        if (out_ready) state_n = S_COLON;
      end
      S_COLON: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_COLON;
        if (out_ready) begin
          case (rec_type)
            ENC_STR: state_n = S_SQ1;
            ENC_INT: state_n = S_CONV;
            default: state_n = S_LIT;
          endcase
        end
      end
      S_SQ1: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_QUOTE;
        if (out_ready) state_n = (rec_str_len == '0) ? S_SQ2 : S_STR;
      end
      S_SQ2: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_QUOTE;
        if (out_ready) begin
          first_n = 1'b0;
          state_n = rec_last ? S_CLOSE : S_IDLE;
        end
      end
      S_LIT: begin
        out_valid = 1'b1;
        out_data  = lit_char(rec_type == ENC_NULL, rec_bool, idx[2:0]);
        if (out_ready) begin
          if ((idx + 8'd1) == 8'(lit_len(rec_type == ENC_NULL, rec_bool))) begin
            idx_n   = '0;
            first_n = 1'b0;
            state_n = rec_last ? S_CLOSE : S_IDLE;
          end else begin
            idx_n = idx + 8'd1;
          end
        end
      end
      S_CONV: begin
        step = 1'b1;
        if (conv_done) begin
          idx_n   = '0;
          state_n = S_NUM;
        end
      end
      S_NUM: begin
        out_valid = 1'b1;
        out_data  = (neg && (idx == 8'd0)) ? JSON_CH_MINUS : (JSON_CH_ZERO + {4'h0, digits[dpos]});
        if (out_ready) begin
          if ((idx + 8'd1) == num_total) begin
            idx_n   = '0;
            first_n = 1'b0;
            state_n = rec_last ? S_CLOSE : S_IDLE;
          end else begin
            idx_n = idx + 8'd1;
          end
        end
      end
      S_CLOSE: begin
        out_valid = 1'b1;
        out_data  = JSON_CH_RBRACE;
        out_last  = 1'b1;
        if (out_ready) begin
          in_obj_n = 1'b0;
          first_n  = 1'b1;
          state_n  = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // State register, object context and the one-cycle error pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      idx       <= '0;
      esc_pos   <= '0;
      in_obj    <= 1'b0;
      first_fld <= 1'b1;
      err_valid <= 1'b0;
      err_code  <= ENC_OK;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      esc_pos   <= esc_n;
      in_obj    <= in_obj_n;
      first_fld <= first_n;
      err_valid <= accept && (chk_code != ENC_OK);
      err_code  <= (accept && (chk_code != ENC_OK)) ? chk_code : ENC_OK;
    end
  end

  // Record capture; held unchanged until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      rec_key     <= '0;
      rec_key_len <= '0;
      rec_type    <= ENC_INT;
      rec_bool    <= 1'b0;
      rec_str     <= '0;
      rec_str_len <= '0;
      rec_last    <= 1'b0;
      rec_bad     <= 1'b0;
    end else if (accept) begin
      rec_key     <= fld_key;
      rec_key_len <= fld_key_len;
      rec_type    <= in_type;
      rec_bool    <= fld_int[0];
      rec_str     <= fld_str;
      rec_str_len <= fld_str_len;
      rec_last    <= fld_last;
      rec_bad     <= (chk_code != ENC_OK);
    end
  end

endmodule

// File: tb/tb_json_obj_encoder.sv
// Directed bench for json_obj_encoder: objects, errors, stalls and mid-object reset.
// Latency: checks first byte one cycle after accept.
// Backpressure: drives out_ready steady or toggling; checks bytes hold while stalled.
module tb_json_obj_encoder;
  import json_pkg::*;

  logic         clk;
  logic         rst;
  logic         fld_valid;
  logic         fld_ready;
  logic [63:0]  fld_key;
  logic [3:0]   fld_key_len;
  logic [1:0]   fld_type;
  logic [31:0]  fld_int;
  logic [127:0] fld_str;
  logic [4:0]   fld_str_len;
  logic         fld_last;
  logic         out_valid;
  logic         out_ready;
  logic [7:0]   out_data;
  logic         out_last;
  logic         err_valid;
  logic [1:0]   err_code;

  int   n_checks = 0;
  int   n_fail   = 0;
  logic [7:0] q[$];
  logic       lq[$];
  int   err_cnt  = 0;
  logic [1:0] err_last = 2'd0;
  logic       stall_pend = 1'b0;
  logic [8:0] stall_val = 9'd0;
  bit         ready_mode = 1'b0;

  json_obj_encoder #(.MAX_KEY(8), .MAX_STR(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fld_valid   (fld_valid),
    .fld_ready   (fld_ready),
    .fld_key     (fld_key),
    .fld_key_len (fld_key_len),
    .fld_type    (fld_type),
    .fld_int     (fld_int),
    .fld_str     (fld_str),
    .fld_str_len (fld_str_len),
    .fld_last    (fld_last),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .err_valid   (err_valid),
    .err_code    (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Collect transferred bytes, error pulses, and check stalled bytes stay put.
  always @(negedge clk) begin
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (stall_pend && out_valid)
        check_eq("stall_hold", {23'd0, out_last, out_data}, {23'd0, stall_val});
      stall_pend = out_valid && !out_ready;
      stall_val  = {out_last, out_data};
      if (out_valid && out_ready) begin
        q.push_back(out_data);
        lq.push_back(out_last);
      end
      if (err_valid) begin
        err_cnt++;
        err_last = err_code;
      end
    end
  end

  // Sink ready: steady high or toggling every cycle.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = ready_mode ? ~out_ready : 1'b1;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_field(input string k, input int klen, input logic [1:0] t,
                            input logic [31:0] iv, input string s, input int slen, input bit last);
    logic [63:0]  kb;
    logic [127:0] sb;
    int n;
    kb = '0;
    sb = '0;
    for (int i = 0; i < k.len() && i < 8; i++) kb[8*i +: 8] = k[i];
    for (int i = 0; i < s.len() && i < 16; i++) sb[8*i +: 8] = s[i];
    n = 0;
    while (!fld_ready && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 500) check_eq("fld_ready_timeout", 0, 1);
    fld_key     = kb;
    fld_key_len = 4'(klen);
    fld_type    = t;
    fld_int     = iv;
    fld_str     = sb;
    fld_str_len = 5'(slen);
    fld_last    = last;
    fld_valid   = 1'b1;
    @(posedge clk);
    #1;
    fld_valid   = 1'b0;
  endtask

  task automatic check_obj(input string tag, input string exp);
    int n;
    int nl;
    n = 0;
    while (!(lq.size() > 0 && lq[lq.size()-1]) && n < 2000) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 2000) check_eq({tag, "_timeout"}, 0, 1);
    check_eq({tag, "_len"}, q.size(), exp.len());
    for (int i = 0; i < exp.len(); i++)
      check_eq($sformatf("%s_b%0d", tag, i), (i < q.size()) ? {24'd0, q[i]} : 32'hFFFF, {24'd0, exp[i]});
    nl = 0;
    foreach (lq[i]) if (lq[i]) nl++;
    check_eq({tag, "_nlast"}, nl, 1);
    q.delete();
    lq.delete();
  endtask

  initial begin
    int e0;
    rst         = 1'b1;
    fld_valid   = 1'b0;
    fld_key     = '0;
    fld_key_len = '0;
    fld_type    = '0;
    fld_int     = '0;
    fld_str     = '0;
    fld_str_len = '0;
    fld_last    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_fld_ready", fld_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("init_out_valid", out_valid, 0);
    check_eq("init_out_data", out_data, 0);
    check_eq("init_out_last", out_last, 0);
    check_eq("init_err_valid", err_valid, 0);
    check_eq("init_err_code", err_code, 0);
    check_eq("init_fld_ready", fld_ready, 1);

    // 1: single integer zero field
    send_field("a", 1, ENC_INT, 32'd0, "", 0, 1'b1);
    check_eq("t1_lat_valid", out_valid, 1);
    check_eq("t1_lat_data", out_data, 8'h7B);
    check_eq("t1_busy", fld_ready, 0);
    check_obj("t1", "{\"a\":0}");

    // 2: most negative integer then boolean true
    send_field("x", 1, ENC_INT, 32'h8000_0000, "", 0, 1'b0);
    send_field("y", 1, ENC_BOOL, 32'd1, "", 0, 1'b1);
    check_obj("t2", "{\"x\":-2147483648,\"y\":true}");

    // 3: string and null under toggling backpressure
    ready_mode = 1'b1;
    send_field("s", 1, ENC_STR, 32'd0, "hi", 2, 1'b0);
    send_field("n", 1, ENC_NULL, 32'd0, "", 0, 1'b1);
    check_obj("t3", "{\"s\":\"hi\",\"n\":null}");
    ready_mode = 1'b0;
    @(posedge clk);
    #1;

    // 4: empty key dropped, then empty string value
    e0 = err_cnt;
    send_field("", 0, ENC_INT, 32'd5, "", 0, 1'b0);
    send_field("k", 1, ENC_STR, 32'd0, "", 0, 1'b1);
    check_obj("t4", "{\"k\":\"\"}");
    check_eq("t4_err_cnt", err_cnt - e0, 1);
    check_eq("t4_err_code", err_last, ENC_BAD_KEY);

    // 4b: oversized string as the only, closing field yields {}
    e0 = err_cnt;
    send_field("q", 1, ENC_STR, 32'd0, "abcdefghijklmnop", 17, 1'b1);
    check_obj("t4b", "{}");
    check_eq("t4b_err_cnt", err_cnt - e0, 1);
    check_eq("t4b_err_code", err_last, ENC_BAD_STR);

    // 4c: oversized key closes an open object with a lone brace
    e0 = err_cnt;
    send_field("a", 1, ENC_INT, 32'd1234, "", 0, 1'b0);
    send_field("abcdefgh", 9, ENC_INT, 32'd1, "", 0, 1'b1);
    check_obj("t4c", "{\"a\":1234}");
    check_eq("t4c_err_cnt", err_cnt - e0, 1);
    check_eq("t4c_err_code", err_last, ENC_BAD_KEY);

    // 5: quote inside a string value
    e0 = err_cnt;
    send_field("z", 1, ENC_INT, 32'd7, "", 0, 1'b0);
    send_field("e", 1, ENC_STR, 32'd0, "a\"b", 3, 1'b1);
`ifdef JSON_ENC_ESCAPE_EN
    check_obj("t5", "{\"z\":7,\"e\":\"a\\\"b\"}");
    check_eq("t5_err_cnt", err_cnt - e0, 0);
`else
    check_obj("t5", "{\"z\":7}");
    check_eq("t5_err_cnt", err_cnt - e0, 1);
    check_eq("t5_err_code", err_last, ENC_BAD_CHAR);
`endif

    // 6: reset after {"ab has been emitted
    send_field("ab", 2, ENC_STR, 32'd0, "hello", 5, 1'b0);
    begin
      int n;
      n = 0;
      while (q.size() < 4 && n < 100) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (n >= 100) check_eq("t6_timeout", 0, 1);
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("t6_out_valid", out_valid, 0);
    check_eq("t6_fld_ready", fld_ready, 1);
    check_eq("t6_trunc_len", q.size(), 4);
    check_eq("t6_trunc_b3", (q.size() > 3) ? {24'd0, q[3]} : 32'hFFFF, 8'h62);
    q.delete();
    lq.delete();
    send_field("c", 1, ENC_BOOL, 32'd0, "", 0, 1'b1);
    check_eq("t6_restart_data", out_data, 8'h7B);
    check_obj("t6", "{\"c\":false}");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
